// File: rtl/btb_sa.sv
// Set-associative branch target buffer: 1-cycle registered lookup, taken-branch allocate with
// per-set round-robin replacement, optional drop on not-taken, whole-table flush.
module btb_sa #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned NUM_SETS        = 64,
    parameter int unsigned NUM_WAYS        = 2,
    parameter int unsigned TAG_BITS        = 16,
    parameter int unsigned INVAL_NOT_TAKEN = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            lk_valid,
    input  logic [XLEN-1:0] lk_pc,
    input  logic            lk_cond_branch,
    input  logic            lk_pred_taken,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            flush,
    output logic            rsp_valid,
    output logic            rsp_hit,
    output logic [XLEN-1:0] rsp_pc,
    output logic [XLEN-1:0] rsp_target
);

    localparam int unsigned IDX_BITS = $clog2(NUM_SETS);
    localparam int unsigned WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
    logic [WAY_BITS-1:0] ptr_q    [NUM_SETS];
    logic [TAG_BITS-1:0] tag_q    [NUM_SETS][NUM_WAYS];
    logic [XLEN-1:0]     target_q [NUM_SETS][NUM_WAYS];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;
    logic [XLEN-1:0]     lk_hit_target;
    logic [XLEN-1:0]     lk_next;

    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_match;
    logic [WAY_BITS-1:0] upd_match_way;
    logic                upd_has_free;
    logic [WAY_BITS-1:0] upd_free_way;
    logic [WAY_BITS-1:0] upd_way;
    logic [WAY_BITS-1:0] ptr_inc;
    logic                unused_pc_bits;

    assign lk_idx  = lk_pc[IDX_BITS+1:2];
    assign lk_tag  = lk_pc[IDX_BITS+2 +: TAG_BITS];
    assign upd_idx = upd_pc[IDX_BITS+1:2];
    assign upd_tag = upd_pc[IDX_BITS+2 +: TAG_BITS];

    // Low byte-offset bits and bits above the tag never take part in indexing.
    assign unused_pc_bits = ^{lk_pc, upd_pc};

    // Lookup reads pre-update contents; no bypass from a same-cycle update.
    always_comb begin
        lk_hit        = 1'b0;
        lk_hit_target = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit        = 1'b1;
                lk_hit_target = target_q[lk_idx][w];
            end
        end
    end

    assign lk_next = (lk_hit && (!lk_cond_branch || lk_pred_taken))
                     ? lk_hit_target : lk_pc + XLEN'(4);

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        upd_match     = 1'b0;
        upd_match_way = '0;
        upd_has_free  = 1'b0;
        upd_free_way  = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
                upd_match     = 1'b1;
                upd_match_way = WAY_BITS'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[upd_idx][w]) begin
                upd_has_free = 1'b1;
                upd_free_way = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        if (upd_match) begin
            upd_way = upd_match_way;
        end else if (upd_has_free) begin
            upd_way = upd_free_way;
        end else begin
            upd_way = ptr_q[upd_idx];
        end
    end

    assign ptr_inc = (NUM_WAYS == 1) ? '0 : ptr_q[upd_idx] + WAY_BITS'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (flush) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                valid_q[upd_idx][upd_way] <= 1'b1;
                // Pointer only advances when a live entry is displaced.
                if (!upd_match && !upd_has_free) begin
                    ptr_q[upd_idx] <= ptr_inc;
                end
            end else if ((INVAL_NOT_TAKEN != 0) && upd_match) begin
                valid_q[upd_idx][upd_match_way] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (upd_valid && upd_taken && !flush) begin
            tag_q[upd_idx][upd_way]    <= upd_tag;
            target_q[upd_idx][upd_way] <= upd_target;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_pc     <= '0;
            rsp_target <= '0;
        end else begin
            rsp_valid  <= lk_valid && !flush;
            rsp_hit    <= lk_valid && !flush && lk_hit;
            rsp_pc     <= lk_pc;
            rsp_target <= lk_next;
        end
    end

endmodule

// File: tb/tb_btb_sa.sv
// Self-checking bench for btb_sa: directed scenarios plus randomized traffic against a
// behavioural table model indexed by plain PC arithmetic.
module tb_btb_sa;

    localparam int NS = 64;
    localparam int NW = 2;

    logic        clock;
    logic        reset;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        lk_cond_branch;
    logic        lk_pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [31:0] rsp_pc;
    logic [31:0] rsp_target;

    int n_checks;
    int n_fail;

    // Behavioural table model
    bit        m_v   [NS][NW];
    bit [15:0] m_t   [NS][NW];
    bit [31:0] m_d   [NS][NW];
    int        m_rr  [NS];

    bit        exp_valid;
    bit        exp_hit;
    bit [31:0] exp_target;
    bit [31:0] exp_pc;

    btb_sa dut (
        .clock          (clock),
        .reset          (reset),
        .lk_valid       (lk_valid),
        .lk_pc          (lk_pc),
        .lk_cond_branch (lk_cond_branch),
        .lk_pred_taken  (lk_pred_taken),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .flush          (flush),
        .rsp_valid      (rsp_valid),
        .rsp_hit        (rsp_hit),
        .rsp_pc         (rsp_pc),
        .rsp_target     (rsp_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int m_idx(input bit [31:0] pc);
        return int'((pc / 4) % NS);
    endfunction

    function automatic bit [15:0] m_tag(input bit [31:0] pc);
        return 16'((pc / 256) % 65536);
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) m_v[s][w] = 1'b0;
        end
    endfunction

    function automatic void m_lookup(input bit [31:0] pc, input bit cond, input bit pt);
        int i = m_idx(pc);
        bit [31:0] ht = 0;
        exp_hit = 1'b0;
        for (int w = 0; w < NW; w++)
            if (m_v[i][w] && m_t[i][w] == m_tag(pc)) begin
                exp_hit = 1'b1;
                ht = m_d[i][w];
            end
        exp_target = (exp_hit && (!cond || pt)) ? ht : pc + 32'd4;
        exp_pc = pc;
    endfunction

    function automatic void m_update(input bit [31:0] pc, input bit [31:0] tgt, input bit taken);
        int i = m_idx(pc);
        int hw = -1;
        int fw = -1;
        for (int w = 0; w < NW; w++)
            if (m_v[i][w] && m_t[i][w] == m_tag(pc)) hw = w;
        if (taken) begin
            if (hw < 0) begin
                for (int w = 0; w < NW; w++)
                    if (!m_v[i][w] && fw < 0) fw = w;
                if (fw < 0) begin
                    fw = m_rr[i];
                    m_rr[i] = (m_rr[i] + 1) % NW;
                end
                hw = fw;
            end
            m_v[i][hw] = 1'b1;
            m_t[i][hw] = m_tag(pc);
            m_d[i][hw] = tgt;
        end else if (hw >= 0) begin
            m_v[i][hw] = 1'b0;
        end
    endfunction

    // Drive one cycle of inputs, advance past the edge, keep the model in step.
    task automatic step(input bit lv, input bit [31:0] lpc, input bit lc, input bit lpt,
                        input bit uv, input bit [31:0] upc, input bit [31:0] utgt,
                        input bit ut, input bit fl);
        lk_valid = lv; lk_pc = lpc; lk_cond_branch = lc; lk_pred_taken = lpt;
        upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = ut; flush = fl;
        m_lookup(lpc, lc, lpt);
        exp_valid = lv && !fl;
        @(posedge clock);
        #1;
        if (fl) m_clear();
        else if (uv) m_update(upc, utgt, ut);
        lk_valid = 1'b0; upd_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic lookup(input bit [31:0] pc, input bit cond, input bit pt);
        step(1'b1, pc, cond, pt, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic install(input bit [31:0] pc, input bit [31:0] tgt, input bit taken);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pc, tgt, taken, 1'b0);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_pc, rsp_target} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b h=%b pc=%h t=%h, want all 0",
                     rsp_valid, rsp_hit, rsp_pc, rsp_target);
        end
        #7 reset = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_rsp: got rsp_valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_cold_miss();
        lookup(32'h0000_1000, 1'b0, 1'b0);
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_target, rsp_pc} !== {1'b1, 1'b0, 32'h1004, 32'h1000}) begin
            n_fail++;
            $display("FAIL cold_miss: got v=%b h=%b t=%h pc=%h, want 1 0 00001004 00001000",
                     rsp_valid, rsp_hit, rsp_target, rsp_pc);
        end
    endtask

    task automatic test_install_hit();
        install(32'h1000, 32'h2000, 1'b1);
        lookup(32'h1000, 1'b1, 1'b1);
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_target} !== {1'b1, 1'b1, 32'h2000}) begin
            n_fail++;
            $display("FAIL hit_pred_taken: got v=%b h=%b t=%h, want 1 1 00002000",
                     rsp_valid, rsp_hit, rsp_target);
        end
        lookup(32'h1000, 1'b1, 1'b0);
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_target} !== {1'b1, 1'b1, 32'h1004}) begin
            n_fail++;
            $display("FAIL hit_pred_not_taken: got v=%b h=%b t=%h, want 1 1 00001004",
                     rsp_valid, rsp_hit, rsp_target);
        end
    endtask

    task automatic test_conflict();
        bit [31:0] pcs [4] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
        bit        want [4];
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) install(pcs[k], pcs[k] + 32'h100, 1'b1);
        want = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            lookup(pcs[k], 1'b0, 1'b0);
            n_checks++;
            if (rsp_hit !== want[k] ||
                rsp_target !== (want[k] ? pcs[k] + 32'h100 : pcs[k] + 32'd4)) begin
                n_fail++;
                $display("FAIL conflict3_%0d: got h=%b t=%h, want h=%b", k, rsp_hit,
                         rsp_target, want[k]);
            end
        end
        install(32'h4000, 32'h4100, 1'b1);
        want = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            lookup(pcs[k], 1'b0, 1'b0);
            n_checks++;
            if (rsp_hit !== want[k]) begin
                n_fail++;
                $display("FAIL conflict4_%0d: got h=%b, want h=%b", k, rsp_hit, want[k]);
            end
        end
    endtask

    task automatic test_not_taken_inval();
        install(32'h1000, 32'h2000, 1'b1);
        install(32'h1000, 32'h0, 1'b0);
        lookup(32'h1000, 1'b0, 1'b0);
        n_checks++;
        if ({rsp_hit, rsp_target} !== {1'b0, 32'h1004}) begin
            n_fail++;
            $display("FAIL not_taken_inval: got h=%b t=%h, want 0 00001004", rsp_hit, rsp_target);
        end
    endtask

    task automatic test_same_cycle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h1000, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0);
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_target} !== {1'b1, 1'b0, 32'h1004}) begin
            n_fail++;
            $display("FAIL same_cycle_no_bypass: got v=%b h=%b t=%h, want 1 0 00001004",
                     rsp_valid, rsp_hit, rsp_target);
        end
        lookup(32'h1000, 1'b0, 1'b0);
        n_checks++;
        if ({rsp_hit, rsp_target} !== {1'b1, 32'h2000}) begin
            n_fail++;
            $display("FAIL same_cycle_next: got h=%b t=%h, want 1 00002000", rsp_hit, rsp_target);
        end
    endtask

    task automatic test_flush();
        install(32'h1000, 32'h2000, 1'b1);
        step(1'b1, 32'h1000, 1'b0, 1'b0, 1'b1, 32'h5000, 32'h6000, 1'b1, 1'b1);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drops_rsp: got rsp_valid=%b, want 0", rsp_valid);
        end
        lookup(32'h1000, 1'b0, 1'b0);
        n_checks++;
        if ({rsp_valid, rsp_hit} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_clears: got v=%b h=%b, want 1 0", rsp_valid, rsp_hit);
        end
        lookup(32'h5000, 1'b0, 1'b0);
        n_checks++;
        if (rsp_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_over_update: got h=%b, want 0", rsp_hit);
        end
    endtask

    task automatic test_random();
        bit lv, lc, lpt, uv, ut, fl;
        bit [31:0] lpc, upc, utgt;
        for (int n = 0; n < 500; n++) begin
            lv   = ($urandom_range(0, 3) != 0);
            lc   = $urandom_range(0, 1) == 1;
            lpt  = $urandom_range(0, 1) == 1;
            uv   = $urandom_range(0, 1) == 1;
            ut   = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 59) == 0);
            lpc  = ($urandom_range(0, 255) << 24) | ($urandom_range(1, 5) << 8)
                 | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            upc  = ($urandom_range(0, 255) << 24) | ($urandom_range(1, 5) << 8)
                 | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            utgt = $urandom;
            step(lv, lpc, lc, lpt, uv, upc, utgt, ut, fl);
            n_checks++;
            if (rsp_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b, want %b", n, rsp_valid, exp_valid);
            end else if (exp_valid) begin
                n_checks++;
                if (rsp_hit !== exp_hit || rsp_target !== exp_target || rsp_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL rand_rsp[%0d]: got h=%b t=%h pc=%h, want h=%b t=%h pc=%h", n,
                             rsp_hit, rsp_target, rsp_pc, exp_hit, exp_target, exp_pc);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        install(32'h1000, 32'h2000, 1'b1);
        lookup(32'h1000, 1'b0, 1'b0);
        n_checks++;
        if ({rsp_valid, rsp_hit} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_hit: got v=%b h=%b, want 1 1", rsp_valid, rsp_hit);
        end
        lk_valid = 1'b1; lk_pc = 32'h1000; lk_cond_branch = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_pc, rsp_target} !== 66'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b h=%b pc=%h t=%h, want all 0",
                     rsp_valid, rsp_hit, rsp_pc, rsp_target);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_pending: got rsp_valid=%b, want 0", rsp_valid);
        end
        lk_valid = 1'b0;
        #2 reset = 1'b1;
        m_clear();
        lookup(32'h1000, 1'b0, 1'b0);
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_target} !== {1'b1, 1'b0, 32'h1004}) begin
            n_fail++;
            $display("FAIL post_reset_miss: got v=%b h=%b t=%h, want 1 0 00001004",
                     rsp_valid, rsp_hit, rsp_target);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b0;
        lk_valid = 1'b0; lk_pc = '0; lk_cond_branch = 1'b0; lk_pred_taken = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; flush = 1'b0;
        m_clear();
        #1;
        test_reset();
        test_cold_miss();
        test_install_hit();
        test_conflict();
        test_not_taken_inval();
        test_same_cycle();
        test_flush();
        test_random();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
